// File: rtl/fractal_sync_rf_arbiter.sv
// Round-robin arbiter/sequencer sharing the fractal_sync RF check ports among requesters.
// Optional stall counter output enabled by FRACTAL_SYNC_RF_ARB_STALL_CNT_EN.
module fractal_sync_rf_arbiter #(
  parameter int N_REQ    = 4,
  parameter int N_PORTS  = 2,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [ID_WIDTH-1:0] req_id_i     [N_REQ],
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [N_REQ-1:0]    rsp_valid_o,
  output logic [3:0]          rsp_status_o [N_REQ],
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output logic [ID_WIDTH-1:0] rf_id_o      [N_PORTS],
  output logic [N_PORTS-1:0]  rf_check_o,
  input  logic [N_PORTS-1:0]  rf_present_i,
  input  logic [N_PORTS-1:0]  rf_id_err_i,
  input  logic [N_PORTS-1:0]  rf_bypass_i,
  input  logic [N_PORTS-1:0]  rf_ignore_i
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q      [N_REQ];
  state_e              state_d      [N_REQ];
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0]  slot_valid_q, slot_valid_d;
  logic [ID_WIDTH-1:0] slot_id_q    [N_PORTS];
  logic [ID_WIDTH-1:0] slot_id_d    [N_PORTS];
  logic [PTR_W-1:0]    slot_owner_q [N_PORTS];
  logic [PTR_W-1:0]    slot_owner_d [N_PORTS];
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [3:0]          rsp_status_q [N_REQ];
  logic [3:0]          rsp_status_d [N_REQ];
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    granted;

  // Gated by rst_ni so nothing is accepted while reset is held.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = rst_ni && (state_q[i] == S_IDLE) && req_valid_i[i];
    end
  end

  always_comb begin
    int idx;
    int grant_cnt;
    granted   = '0;
    rr_ptr_d  = rr_ptr_q;
    grant_cnt = 0;
    idx       = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      slot_valid_d[k] = 1'b0;
      slot_id_d[k]    = '0;
      slot_owner_d[k] = '0;
    end
    for (int s = 0; s < N_REQ; s++) begin
      idx = int'(rr_ptr_q) + s;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == idx && eligible[i] && grant_cnt < N_PORTS) begin
          granted[i] = 1'b1;
          for (int k = 0; k < N_PORTS; k++) begin
            if (k == grant_cnt) begin
              slot_valid_d[k] = 1'b1;
              slot_id_d[k]    = req_id_i[i];
              slot_owner_d[k] = PTR_W'(i);
            end
          end
          grant_cnt = grant_cnt + 1;
          rr_ptr_d  = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:   if (granted[i]) state_d[i] = S_ISSUED;
        S_ISSUED: state_d[i] = S_RESP;
        S_RESP:   if (rsp_valid_q[i] && rsp_ready_i[i]) state_d[i] = S_IDLE;
        default:  state_d[i] = S_IDLE;
      endcase
    end
  end

  // An owner is in ISSUED while its slot is live, so capture never meets an accept.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_status_d[i] = rsp_status_q[i];
      if (rsp_valid_q[i] && rsp_ready_i[i]) rsp_valid_d[i] = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        if (slot_valid_q[k] && slot_owner_q[k] == PTR_W'(i)) begin
          rsp_valid_d[i]  = 1'b1;
          rsp_status_d[i] = {rf_id_err_i[k], rf_bypass_i[k], rf_ignore_i[k], rf_present_i[k]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      slot_valid_q <= '0;
      rsp_valid_q  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i]      <= S_IDLE;
        rsp_status_q[i] <= '0;
      end
      for (int k = 0; k < N_PORTS; k++) begin
        slot_id_q[k]    <= '0;
        slot_owner_q[k] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      slot_valid_q <= slot_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i]      <= state_d[i];
        rsp_status_q[i] <= rsp_status_d[i];
      end
      for (int k = 0; k < N_PORTS; k++) begin
        slot_id_q[k]    <= slot_id_d[k];
        slot_owner_q[k] <= slot_owner_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      rf_id_o[k] = slot_valid_q[k] ? slot_id_q[k] : '0;
    end
  end

  assign rf_check_o   = slot_valid_q;
  assign req_ready_o  = granted;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;

`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(eligible & ~granted) && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fractal_sync_rf_arbiter.sv
// Directed bench for fractal_sync_rf_arbiter with a 4-register RF model and per-requester
// response scoreboard. Stall counter checks are active when FRACTAL_SYNC_RF_ARB_STALL_CNT_EN is set.
module tb_fractal_sync_rf_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_id     [4];
  logic [3:0] req_ready;
  logic [3:0] rsp_valid;
  logic [3:0] rsp_status [4];
  logic [3:0] rsp_ready;
  logic [3:0] rf_id      [2];
  logic [1:0] rf_check;
  logic [1:0] rf_present, rf_id_err, rf_bypass, rf_ignore;
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_base;
`endif

  fractal_sync_rf_arbiter #(.N_REQ(4), .N_PORTS(2), .ID_WIDTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_id_i     (req_id),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_status_o (rsp_status),
    .rsp_ready_i  (rsp_ready),
    .rf_id_o      (rf_id),
    .rf_check_o   (rf_check),
    .rf_present_i (rf_present),
    .rf_id_err_i  (rf_id_err),
    .rf_bypass_i  (rf_bypass),
    .rf_ignore_i  (rf_ignore)
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RF model: 4 registers, local id = id[3:1]; first arrival sets, second reports present and clears.
  logic [3:0] rf_bits;
  logic [2:0] lid0, lid1;
  logic       err0, err1, same;
  logic [1:0] solo;

  always_comb begin
    lid0 = rf_id[0][3:1];
    lid1 = rf_id[1][3:1];
    err0 = rf_check[0] && (lid0 > 3'd3);
    err1 = rf_check[1] && (lid1 > 3'd3);
    same = rf_check[0] && rf_check[1] && !err0 && (lid0 == lid1);
    rf_id_err  = {err1, err0};
    rf_bypass  = {1'b0, same};
    rf_ignore  = {same, 1'b0};
    solo[0]    = rf_check[0] && !err0 && !same;
    solo[1]    = rf_check[1] && !err1 && !same;
    rf_present = {solo[1] && rf_bits[lid1[1:0]], solo[0] && rf_bits[lid0[1:0]]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf_bits <= '0;
    else begin
      if (solo[0]) rf_bits[lid0[1:0]] <= ~rf_bits[lid0[1:0]];
      if (solo[1]) rf_bits[lid1[1:0]] <= ~rf_bits[lid1[1:0]];
    end
  end

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q [4][$];
  logic [3:0] prev_valid = '0;
  logic [3:0] prev_ready = '0;
  logic [3:0] prev_status [4] = '{default: 4'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a rising rsp_valid pops the requester's expected status; a held response must not change.
  task automatic monitor();
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid[i] && !prev_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          total++;
          bad++;
          $error("FAIL rsp%0d_unexpected observed=%0h expected=none", i, rsp_status[i]);
        end else begin
          chk($sformatf("rsp%0d_status", i), 32'(rsp_status[i]), 32'(exp_q[i].pop_front()));
        end
      end else if (prev_valid[i] && !prev_ready[i]) begin
        chk($sformatf("rsp%0d_hold_valid", i), 32'(rsp_valid[i]), 32'd1);
        chk($sformatf("rsp%0d_hold_status", i), 32'(rsp_status[i]), 32'(prev_status[i]));
      end
      prev_valid[i]  = rsp_valid[i];
      prev_ready[i]  = rsp_ready[i];
      prev_status[i] = rsp_status[i];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int r, input logic [3:0] id, input logic [3:0] exp);
    req_valid[r] = 1'b1;
    req_id[r]    = id;
    #1;
    chk("single_ready", 32'(req_ready), 32'(4'b0001 << r));
    exp_q[r].push_back(exp);
    cyc();
    req_valid[r] = 1'b0;
    #1;
    chk("single_check", 32'(rf_check), 32'h1);
    chk("single_rf_id", 32'(rf_id[0]), 32'(id));
    cyc();
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << r));
    cyc();
    cyc();
  endtask

  // All four requesters valid; ready0/ready1 are the expected grant sets of the two cycles.
  task automatic burst(input logic [3:0] ids [4], input logic [3:0] exps [4],
                       input logic [3:0] ready0, input logic [3:0] ready1);
    logic [3:0] ord [4];
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (ready0[i]) begin ord[n] = ids[i]; n++; end
    for (int i = 0; i < 4; i++) if (ready1[i]) begin ord[n] = ids[i]; n++; end
    req_valid = 4'hF;
    req_id    = ids;
    #1;
    chk("burst_ready0", 32'(req_ready), 32'(ready0));
    for (int i = 0; i < 4; i++) exp_q[i].push_back(exps[i]);
    cyc();
    req_valid = ~ready0;
    #1;
    chk("burst_ready1", 32'(req_ready), 32'(ready1));
    chk("burst_check1", 32'(rf_check), 32'h3);
    chk("burst_id1_p0", 32'(rf_id[0]), 32'(ord[0]));
    chk("burst_id1_p1", 32'(rf_id[1]), 32'(ord[1]));
    cyc();
    req_valid = '0;
    #1;
    chk("burst_check2", 32'(rf_check), 32'h3);
    chk("burst_id2_p0", 32'(rf_id[0]), 32'(ord[2]));
    chk("burst_id2_p1", 32'(rf_id[1]), 32'(ord[3]));
    chk("burst_rsp_a", 32'(rsp_valid), 32'(ready0));
    cyc();
    #1;
    chk("burst_rsp_b", 32'(rsp_valid), 32'(ready1));
    cyc();
    cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_id    = '{default: 4'h0};
    rsp_ready = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_check", 32'(rf_check), 32'h0);
    chk("rst_rf_id0", 32'(rf_id[0]), 32'h0);
    chk("rst_status0", 32'(rsp_status[0]), 32'h0);
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 32'h0);
`endif
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin from pointer 0: first arrivals at every register.
    burst('{4'h0, 4'h2, 4'h4, 4'h6}, '{4'b0000, 4'b0000, 4'b0000, 4'b0000}, 4'b0011, 4'b1100);
    // Pointer back at 0; second arrivals report present.
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    stall_base = stall_cnt;
`endif
    burst('{4'h1, 4'h3, 4'h5, 4'h7}, '{4'b0001, 4'b0001, 4'b0001, 4'b0001}, 4'b0011, 4'b1100);
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    chk("stall_delta", stall_cnt, stall_base + 32'd1);
`endif

    // Same-id collision on both ports.
    req_valid = 4'b0011;
    req_id[0] = 4'h4;
    req_id[1] = 4'h4;
    #1;
    chk("coll_ready", 32'(req_ready), 32'h3);
    exp_q[0].push_back(4'b0100);
    exp_q[1].push_back(4'b0010);
    cyc();
    req_valid = '0;
    #1;
    chk("coll_check", 32'(rf_check), 32'h3);
    cyc();
    #1;
    chk("coll_rsp_valid", 32'(rsp_valid), 32'h3);
    cyc();
    cyc();

    // Pointer now 2: requesters 2,3 first; both ids out of range.
    burst('{4'h0, 4'h6, 4'hE, 4'hC}, '{4'b0000, 4'b0000, 4'b1000, 4'b1000}, 4'b1100, 4'b0011);

    single(0, 4'h2, 4'b0000);
    single(0, 4'h2, 4'b0001);

    // Backpressure with valid held high.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_id[0]    = 4'h0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h1);
    exp_q[0].push_back(4'b0001);
    cyc();
    #1;
    chk("bp_ready_issued", 32'(req_ready[0]), 32'h0);
    cyc();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", 32'(rsp_valid[0]), 32'h1);
      chk("bp_hold_ready", 32'(req_ready[0]), 32'h0);
      cyc();
    end
    rsp_ready[0] = 1'b1;
    #1;
    chk("bp_accept_ready", 32'(req_ready[0]), 32'h0);
    exp_q[0].push_back(4'b0000);
    cyc();
    #1;
    chk("bp_drop_valid", 32'(rsp_valid[0]), 32'h0);
    chk("bp_regrant", 32'(req_ready[0]), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    #1;
    chk("bp_rsp2_valid", 32'(rsp_valid[0]), 32'h1);
    cyc();
    cyc();

    // Reset while a slot is issuing.
    req_valid[1] = 1'b1;
    req_id[1]    = 4'h2;
    #1;
    chk("rst2_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 4'hF;
    #1;
    chk("rst2_check_pre", 32'(rf_check), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst2_check", 32'(rf_check), 32'h0);
    chk("rst2_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst2_ready", 32'(req_ready), 32'h0);
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    chk("rst2_stall", stall_cnt, 32'h0);
`endif
    req_valid = '0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rst2_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rst2_no_check", 32'(rf_check), 32'h0);
      cyc();
    end

    for (int i = 0; i < 4; i++) chk($sformatf("pending_rsp%0d", i), exp_q[i].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fractal_sync_rf_arbiter.md
Name: fractal_sync_rf_arbiter

Overview:
Round-robin arbiter and sequencer placed in front of a fractal_sync 1D local register file. It shares the RF's N_PORTS check ports among N_REQ synchronization requesters using a valid/ready handshake. It registers the granted ids onto the RF ports and captures each RF outcome (present, bypass, ignore, id_err) into a per-requester response held until the requester accepts it.

Parameters:
N_REQ, 4, number of requesters (>= N_PORTS)
N_PORTS, 2, number of RF check ports (>= 1)
ID_WIDTH, 4, barrier id width, passed unchanged to the RF

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
req_valid_i[N_REQ]  in  1  request valid
req_id_i[N_REQ]  in  ID_WIDTH  barrier id; must stay stable while valid is high
req_ready_o[N_REQ]  out  1  grant/accept, combinational
rsp_valid_o[N_REQ]  out  1  response valid
rsp_status_o[N_REQ]  out  4  {id_err, bypass, ignore, present}
rsp_ready_i[N_REQ]  in  1  response accept
rf_id_o[N_PORTS]  out  ID_WIDTH  id driven to the RF
rf_check_o[N_PORTS]  out  1  RF check strobe
rf_present_i / rf_id_err_i / rf_bypass_i / rf_ignore_i [N_PORTS]  in  1  RF outcome, combinational in the same cycle as the check

Behaviour:
- Reset (asynchronous, rst_ni low): all requester FSMs go to IDLE. Port slots are invalid. rr_ptr=0. All rsp_valid_o, rsp_status_o, rf_check_o and rf_id_o are 0. req_ready_o is 0 while reset is asserted. Any in-flight request is dropped with no response.
- Per-requester FSM:
  - IDLE -> ISSUED when granted (req_valid_i & req_ready_o).
  - ISSUED -> RESP on the next edge, while the RF outcome is captured.
  - RESP -> IDLE on rsp_valid_o & rsp_ready_i.
- Eligibility: a requester is eligible only when it is IDLE with valid high. A requester in ISSUED or RESP is never granted. A requester completing its response handshake is not re-granted in the same cycle.
- Arbitration: scan eligible requesters starting at rr_ptr, wrapping modulo N_REQ. Grant up to N_PORTS of them. The k-th grant in scan order goes to port slot k (k = 0..grants-1).
  - req_ready_o[i] = granted[i].
  - If at least one grant is made: rr_ptr <= (index of last granted + 1) mod N_REQ. With no grants, rr_ptr holds.
- Port slots (registered): slot_valid, slot_id and slot_owner ($clog2(N_REQ) bits) are loaded at the grant edge.
  - rf_check_o[k] = slot_valid[k].
  - rf_id_o[k] = slot_id[k], or 0 when the slot is invalid.
  - Every slot issues in its single valid cycle, so slots are always free for the next grants. Throughput is N_PORTS requests per cycle.
- Capture: on the edge after issue, the response register of the slot's owner is loaded.
  - rsp_status <= {rf_id_err_i[k], rf_bypass_i[k], rf_ignore_i[k], rf_present_i[k]}.
  - rsp_valid <= 1.
- Latency: grant in cycle T, rf_check_o in T+1, rsp_valid_o in T+2.
- Holding: status is stable while rsp_valid_o=1 and rsp_ready_i=0. rsp_valid_o drops on the edge after acceptance.
- Same-id requests granted in one cycle are resolved by the RF (the lower port bypasses, higher ports ignore). The arbiter only forwards those outcomes.

Optional Feature:
FRACTAL_SYNC_RF_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (32 bits), reset to 0. It increments by 1 on every cycle in which at least one requester has req_valid_i high, is IDLE, and is not granted. It saturates at 32'hFFFF_FFFF.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
Default parameters; the RF is instantiated with N_REGS=4, so local id = id[3:1].
- Single request: req0 with id 4'h2 in cycle 0 -> req_ready_o[0]=1 in cycle 0; rf_check_o[0]=1 and rf_id_o[0]=4'h2 in cycle 1; rsp_valid_o[0]=1 with status 4'b0000 in cycle 2. Accepting it, then repeating id 4'h2 -> status 4'b0001 (present).
- Arbitration: all four requesters valid after reset with distinct ids -> cycle 0 grants req0->port0 and req1->port1; cycle 1 grants req2->port0 and req3->port1; rr_ptr returns to 0; no requester is granted twice before its response is accepted.
- Same-id collision: req0 and req1 both id 4'h4 in the same cycle -> rsp_status_o[0]=4'b0100 (bypass), rsp_status_o[1]=4'b0010 (ignore), both in cycle 2.
- Id error: req2 with id 4'hE (local id 7 > 3) -> rsp_status_o[2]=4'b1000.
- Backpressure: rsp_ready_i[0]=0 for 5 cycles with req_valid_i[0] held high -> rsp_valid_o[0] and its status stay stable, req_ready_o[0]=0 throughout; once rsp_ready_i[0]=1, req0 is re-granted no earlier than the following cycle.
- Reset mid-operation: drop rst_ni during the cycle a slot is ISSUED -> rf_check_o, rsp_valid_o and req_ready_o go to 0 immediately (asynchronously) and no response is produced after release; if FRACTAL_SYNC_RF_ARB_STALL_CNT_EN is defined, stall_cnt_o=0.
